// File: rtl/dmem_bytelane_if.sv
// +------------------------------------------------------------------+
// | dmem_bytelane_if : request/response bus of the byte-lane dmem    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

interface dmem_bytelane_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault
   );
endinterface

`default_nettype wire

// File: rtl/dmem_bytelane.sv
// +------------------------------------------------------------------+
// | dmem_bytelane : RV32I data memory, B/H/W access, registered read |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
`default_nettype none

module dmem_bytelane #(
   parameter int          DEPTH          = 256,
   parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
   parameter bit          CLEAR_ON_RESET = 1'b1
) (
   input  wire logic      clk,
   input  wire logic      rst,
   dmem_bytelane_if.slave bus
);

   localparam int c_AW = $clog2(DEPTH);

   typedef enum logic [0:0] {
      S_CLEAR = 1'b0,
      S_IDLE  = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [c_AW-1:0]  r_clr_idx;
   logic [c_AW-1:0]  w_clr_idx_nxt;
   logic             w_clr_we;

   logic             w_ready;
   logic             w_accept;
   logic [31:0]      w_off;
   logic [c_AW-1:0]  w_idx;
   logic [1:0]       w_lane;
   logic [2:0]       w_f3;
   logic             w_illegal;
   logic             w_range_err;
   logic             w_misal;
   logic             w_fault;
   logic [3:0]       w_be;
   logic [31:0]      w_wlanes;
   logic             w_mem_we;
   logic [31:0]      w_rd_word;
   logic [7:0]       w_byte;
   logic [15:0]      w_half;
   logic [31:0]      w_load;
   logic [31:0]      w_rsp_data;

   logic             r_rsp_valid;
   logic             r_rsp_fault;
   logic [31:0]      r_rsp_rdata;

   always_comb begin
      w_state_nxt   = r_state;
      w_clr_idx_nxt = r_clr_idx;
      w_clr_we      = 1'b0;
      case (r_state)
         S_CLEAR: begin
            if (CLEAR_ON_RESET) begin
               w_clr_we      = 1'b1;
               w_clr_idx_nxt = r_clr_idx + 1'b1;
               if (r_clr_idx == c_AW'(DEPTH - 1)) begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign w_ready       = (r_state == S_IDLE);
   assign w_accept      = bus.req_valid && w_ready;
   assign bus.req_ready = w_ready;

   // Offsets below BASE_ADDR wrap to large values and land in the range fault.
   assign w_off       = bus.req_addr - BASE_ADDR;
   assign w_idx       = w_off[c_AW+1:2];
   assign w_lane      = w_off[1:0];
   assign w_f3        = bus.req_funct3;
   assign w_range_err = |w_off[31:c_AW+2];
   assign w_illegal   = bus.req_we ? (w_f3 > 3'd2)
                                   : ((w_f3 == 3'd3) || (w_f3[2:1] == 2'b11));
   assign w_misal     = ((w_f3[1:0] == 2'b01) && w_off[0]) ||
                        ((w_f3[1:0] == 2'b10) && (w_off[1:0] != 2'b00));
   assign w_fault     = w_illegal || w_range_err || w_misal;
   assign w_mem_we    = w_accept && bus.req_we && !w_fault;

   always_comb begin
      w_be     = 4'b1111;
      w_wlanes = bus.req_wdata;
      case (w_f3[1:0])
         2'b00: begin
            w_be     = 4'b0001 << w_lane;
            w_wlanes = {4{bus.req_wdata[7:0]}};
         end
         2'b01: begin
            w_be     = w_off[1] ? 4'b1100 : 4'b0011;
            w_wlanes = {2{bus.req_wdata[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_wlanes = bus.req_wdata;
         end
      endcase
   end

   // One byte-wide array per lane keeps partial stores free of read-modify-write.
   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_mem [DEPTH];

      always_ff @(posedge clk) begin
         if (w_clr_we) begin
            r_mem[r_clr_idx] <= 8'h00;
         end else if (w_mem_we && w_be[gi]) begin
            r_mem[w_idx] <= w_wlanes[8*gi +: 8];
         end
      end

      assign w_rd_word[8*gi +: 8] = r_mem[w_idx];
   end

   always_comb begin
      w_byte = w_rd_word[7:0];
      case (w_lane)
         2'd0:    w_byte = w_rd_word[7:0];
         2'd1:    w_byte = w_rd_word[15:8];
         2'd2:    w_byte = w_rd_word[23:16];
         default: w_byte = w_rd_word[31:24];
      endcase
      w_half = w_off[1] ? w_rd_word[31:16] : w_rd_word[15:0];
      case (w_f3)
         3'd0:    w_load = {{24{w_byte[7]}}, w_byte};
         3'd4:    w_load = {24'h0, w_byte};
         3'd1:    w_load = {{16{w_half[15]}}, w_half};
         3'd5:    w_load = {16'h0, w_half};
         default: w_load = w_rd_word;
      endcase
      w_rsp_data = (bus.req_we || w_fault) ? 32'h0 : w_load;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_CLEAR;
         r_clr_idx   <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_fault <= 1'b0;
         r_rsp_rdata <= 32'h0;
      end else begin
         r_state     <= w_state_nxt;
         r_clr_idx   <= w_clr_idx_nxt;
         r_rsp_valid <= w_accept;
         r_rsp_fault <= w_accept && w_fault;
         r_rsp_rdata <= w_accept ? w_rsp_data : 32'h0;
      end
   end

   assign bus.rsp_valid = r_rsp_valid;
   assign bus.rsp_fault = r_rsp_fault;
   assign bus.rsp_rdata = r_rsp_rdata;

endmodule

`default_nettype wire
